// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
package sweep_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StApply  = 2'd1,
    StSample = 2'd2,
    StDone   = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle counter: counts cycles a vector has been applied; expire_o flags the last settle cycle.
module sweep_settle_timer
  import sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CntLast);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of a combinational gate, captures its truth table and compares it
// against a reference word latched when the sweep starts.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int unsigned N_IN          = 3,
  parameter int unsigned SETTLE_CYCLES = 4,
  localparam int unsigned TT_W         = 2 ** N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [TT_W-1:0] expected,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] tt,
  output logic            match,
  output logic [TT_W-1:0] mismatch_mask
);

  localparam logic [N_IN:0] IdxLast = (N_IN + 1)'(TT_W - 1);

  sweep_state_t    state_q, state_d;
  logic [TT_W-1:0] exp_q, exp_d;
  logic [TT_W-1:0] tt_q, tt_d;
  logic [TT_W-1:0] mask_q, mask_d;
  logic [N_IN:0]   idx_q, idx_d;
  logic [N_IN-1:0] dut_in_q, dut_in_d;
  logic            match_q, match_d;
  logic            busy_q, done_q;
  logic            timer_clr, timer_en, timer_expire;

  sweep_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (timer_clr),
    .enable_i (timer_en),
    .expire_o (timer_expire)
  );

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    tt_d      = tt_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    dut_in_d  = dut_in_q;
    match_d   = match_q;
    timer_clr = 1'b1;
    timer_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d  = StApply;
          exp_d    = expected;
          tt_d     = '0;
          mask_d   = '0;
          match_d  = 1'b0;
          idx_d    = '0;
          dut_in_d = '0;
        end
      end
      StApply: begin
        timer_clr = 1'b0;
        timer_en  = 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else if (timer_expire) begin
          state_d = StSample;
        end
      end
      StSample: begin
        // The vector on the sample edge is captured even when the sweep is aborted there.
        tt_d[idx_q[N_IN-1:0]] = dut_out;
        if (abort) begin
          state_d = StIdle;
        end else if (idx_q == IdxLast) begin
          state_d = StDone;
          match_d = (tt_d == exp_q);
          mask_d  = tt_d ^ exp_q;
        end else begin
          state_d  = StApply;
          idx_d    = idx_q + 1'b1;
          dut_in_d = dut_in_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      exp_q    <= '0;
      tt_q     <= '0;
      mask_q   <= '0;
      idx_q    <= '0;
      dut_in_q <= '0;
      match_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      tt_q     <= tt_d;
      mask_q   <= mask_d;
      idx_q    <= idx_d;
      dut_in_q <= dut_in_d;
      match_q  <= match_d;
      busy_q   <= (state_d == StApply) || (state_d == StSample);
      done_q   <= (state_d == StDone);
    end
  end

  assign dut_in        = dut_in_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign tt            = tt_q;
  assign match         = match_q;
  assign mismatch_mask = mask_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised and directed bench for truth_table_sweeper; the gate is a lookup table.
module tb_truth_table_sweeper;

  localparam int unsigned N_IN = 3;
  localparam int unsigned TT_W = 8;
  localparam int unsigned S0   = 4;
  localparam int unsigned S1   = 1;
  localparam int unsigned LAT0 = TT_W * (S0 + 1);
  localparam int unsigned LAT1 = TT_W * (S1 + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start, start1, abort, abort1;
  logic [TT_W-1:0] expected;
  logic [TT_W-1:0] gate0, gate1;
  logic [N_IN-1:0] dut_in0, dut_in1;
  logic            dut_out0, dut_out1;
  logic            busy0, busy1, done0, done1, match0, match1;
  logic [TT_W-1:0] tt0, tt1, mask0, mask1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign dut_out0 = gate0[dut_in0];
  assign dut_out1 = gate1[dut_in1];

  truth_table_sweeper #(
    .N_IN          (N_IN),
    .SETTLE_CYCLES (S0)
  ) u_dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .expected      (expected),
    .dut_in        (dut_in0),
    .dut_out       (dut_out0),
    .busy          (busy0),
    .done          (done0),
    .tt            (tt0),
    .match         (match0),
    .mismatch_mask (mask0)
  );

  truth_table_sweeper #(
    .N_IN          (N_IN),
    .SETTLE_CYCLES (S1)
  ) u_dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start1),
    .abort         (abort1),
    .expected      (expected),
    .dut_in        (dut_in1),
    .dut_out       (dut_out1),
    .busy          (busy1),
    .done          (done1),
    .tt            (tt1),
    .match         (match1),
    .mismatch_mask (mask1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected vector on dut_in k cycles after the accepting edge.
  function automatic int unsigned vec_at(input int unsigned k, input int unsigned s);
    int unsigned v;
    v = k / (s + 1);
    return (v > TT_W - 1) ? TT_W - 1 : v;
  endfunction

  task automatic accept0(input logic [TT_W-1:0] g, input logic [TT_W-1:0] e);
    gate0    = g;
    expected = e;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic sweep0(input logic [TT_W-1:0] g, input logic [TT_W-1:0] e, input bit wiggle);
    accept0(g, e);
    check_eq("acc_busy", busy0, 1);
    check_eq("acc_tt", tt0, 0);
    check_eq("acc_match", match0, 0);
    check_eq("acc_dut_in", dut_in0, 0);
    if (wiggle) expected = ~e;
    for (int k = 1; k <= LAT0; k++) begin
      tick();
      check_eq("dut_in_seq", dut_in0, vec_at(k, S0));
      check_eq("done_time", done0, (k == LAT0));
    end
    expected = e;
    check_eq("tt", tt0, g);
    check_eq("match", match0, (g == e));
    check_eq("mask", mask0, g ^ e);
    check_eq("busy_done", busy0, 0);
    tick();
    check_eq("done_pulse", done0, 0);
    check_eq("match_hold", match0, (g == e));
    check_eq("mask_hold", mask0, g ^ e);
  endtask

  task automatic sweep1(input logic [TT_W-1:0] g, input logic [TT_W-1:0] e);
    gate1    = g;
    expected = e;
    start1   = 1'b1;
    tick();
    start1   = 1'b0;
    for (int k = 1; k <= LAT1; k++) begin
      tick();
      check_eq("s1_dut_in", dut_in1, vec_at(k, S1));
      check_eq("s1_done_time", done1, (k == LAT1));
    end
    check_eq("s1_tt", tt1, g);
    check_eq("s1_match", match1, (g == e));
    check_eq("s1_mask", mask1, g ^ e);
    tick();
  endtask

  initial begin
    logic [TT_W-1:0] g, e, part;
    bit seen;

    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; abort = 1'b0; abort1 = 1'b0;
    expected = '0; gate0 = '0; gate1 = '0;
    #12;
    check_eq("rst_busy", busy0, 0);
    check_eq("rst_done", done0, 0);
    check_eq("rst_dut_in", dut_in0, 0);
    check_eq("rst_tt", tt0, 0);
    check_eq("rst_match", match0, 0);
    check_eq("rst_mask", mask0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Gate true only for vectors 4 and 7.
    sweep0(8'h90, 8'h90, 1'b1);
    sweep0(8'h90, 8'h91, 1'b0);
    sweep1(8'h90, 8'h90);
    sweep1(8'h90, 8'h91);

    // Abort ten cycles after start: vectors 0 and 1 already sampled.
    g = 8'($urandom) | 8'h07;
    e = 8'($urandom);
    accept0(g, e);
    for (int k = 1; k <= 9; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    part = '0;
    for (int i = 0; i < TT_W; i++) if ((i + 1) * (S0 + 1) <= 10) part[i] = g[i];
    check_eq("abort_busy", busy0, 0);
    check_eq("abort_done", done0, 0);
    check_eq("abort_tt", tt0, part);
    check_eq("abort_match", match0, 0);
    check_eq("abort_dut_in", dut_in0, vec_at(9, S0));
    seen = 1'b0;
    for (int k = 0; k < LAT0; k++) begin
      tick();
      if (done0 || busy0) seen = 1'b1;
    end
    check_eq("abort_quiet", seen, 0);

    // start together with abort while idle.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_eq("start_abort_idle", busy0, 0);

    // Starts while busy and in DONE are ignored; abort in DONE is ignored.
    g = 8'($urandom);
    e = 8'($urandom);
    accept0(g, e);
    for (int k = 1; k <= LAT0; k++) begin
      if (k == 5) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check_eq("ign_done_time", done0, 1);
    check_eq("ign_tt", tt0, g);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_eq("ign_done_busy", busy0, 0);
    check_eq("ign_done_tt", tt0, g);
    check_eq("ign_done_mask", mask0, g ^ e);
    tick();
    sweep0(~g, e, 1'b0);

    // Reset in the middle of a sweep.
    accept0(8'hFF, 8'hFF);
    for (int k = 1; k <= 19; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy0, 0);
    check_eq("mid_rst_done", done0, 0);
    check_eq("mid_rst_dut_in", dut_in0, 0);
    check_eq("mid_rst_tt", tt0, 0);
    check_eq("mid_rst_match", match0, 0);
    check_eq("mid_rst_mask", mask0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_done", done0, 0);

    for (int n = 0; n < 8; n++) begin
      g = 8'($urandom);
      e = ($urandom_range(0, 1) == 0) ? g : 8'($urandom);
      sweep0(g, e, 1'b1);
      g = 8'($urandom);
      e = ($urandom_range(0, 1) == 0) ? g : g ^ (8'h1 << $urandom_range(0, 7));
      sweep1(g, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
